// File: rtl/csr_trap_seq.sv
// Sequencer/arbiter between the core CSR port, trap entry and mret, and the single-port M-mode CSR file.
// Optional vectored-interrupt redirect is enabled by defining CSR_TRAP_VECTORED_EN.
module csr_trap_seq #(
  parameter logic [31:0] RST_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [11:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  input  logic        exc_req_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  output logic        exc_ack_o,
  input  logic        mret_i,
  output logic        mret_ack_o,
  output logic        busy_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] csr_addr_o,
  output logic        csr_we_o,
  output logic        csr_re_o,
  output logic [31:0] csr_wdata_o,
  output logic        csr_except_o,
  input  logic [31:0] csr_rdata_i
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_C_RD     = 4'd1,
    S_T_EPC    = 4'd2,
    S_T_CAUSE  = 4'd3,
    S_T_ST_RD  = 4'd4,
    S_T_ST_WR  = 4'd5,
    S_T_VEC_RD = 4'd6,
    S_T_VEC_LD = 4'd7,
    S_R_EPC_RD = 4'd8,
    S_R_ST_RD  = 4'd9,
    S_R_ST_WR  = 4'd10,
    S_REDIR    = 4'd11
  } state_t;

  localparam logic [31:0] ADDR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] ADDR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] ADDR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] ADDR_MCAUSE  = 32'h0000_0342;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cause;
  logic [31:0] r_pc;
  logic [31:0] w_target;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M-mode.
  function automatic logic [31:0] f_trap_mstatus(input logic [31:0] st);
    logic [31:0] v;
    v         = st;
    v[7]      = st[3];
    v[3]      = 1'b0;
    v[12:11]  = 2'b11;
    return v;
  endfunction

  function automatic logic [31:0] f_mret_mstatus(input logic [31:0] st);
    logic [31:0] v;
    v    = st;
    v[3] = st[7];
    v[7] = 1'b1;
    return v;
  endfunction

`ifdef CSR_TRAP_VECTORED_EN
  function automatic logic [31:0] f_trap_target(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    if (tvec[1:0] == 2'b01 && cause[31] == 1'b1) begin
      return base + {cause[29:0], 2'b00};
    end else begin
      return base;
    end
  endfunction

  assign w_target = f_trap_target(csr_rdata_i, r_cause);
`else
  assign w_target = {csr_rdata_i[31:2], 2'b00};
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latched trap context and redirect target.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cause       <= 32'h0000_0000;
      r_pc          <= 32'h0000_0000;
      redirect_pc_o <= RST_PC;
    end else begin
      if (r_state == S_IDLE && exc_req_i) begin
        r_cause <= exc_cause_i;
        r_pc    <= exc_pc_i;
      end
      if (r_state == S_T_VEC_LD) begin
        redirect_pc_o <= w_target;
      end else if (r_state == S_R_ST_RD) begin
        redirect_pc_o <= csr_rdata_i & ~32'h0000_0003;
      end
    end
  end

  // Next-state logic; IDLE arbitration is exception > mret > core.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (exc_req_i) begin
          w_next = S_T_EPC;
        end else if (mret_i) begin
          w_next = S_R_EPC_RD;
        end else if (core_req_i && !core_we_i) begin
          w_next = S_C_RD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_C_RD:     w_next = S_IDLE;
      S_T_EPC:    w_next = S_T_CAUSE;
      S_T_CAUSE:  w_next = S_T_ST_RD;
      S_T_ST_RD:  w_next = S_T_ST_WR;
      S_T_ST_WR:  w_next = S_T_VEC_RD;
      S_T_VEC_RD: w_next = S_T_VEC_LD;
      S_T_VEC_LD: w_next = S_REDIR;
      S_R_EPC_RD: w_next = S_R_ST_RD;
      S_R_ST_RD:  w_next = S_R_ST_WR;
      S_R_ST_WR:  w_next = S_REDIR;
      S_REDIR:    w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    core_gnt_o       = 1'b0;
    core_rvalid_o    = 1'b0;
    core_rdata_o     = 32'h0000_0000;
    exc_ack_o        = 1'b0;
    mret_ack_o       = 1'b0;
    busy_o           = 1'b0;
    redirect_valid_o = 1'b0;
    csr_addr_o       = 32'h0000_0000;
    csr_we_o         = 1'b0;
    csr_re_o         = 1'b0;
    csr_wdata_o      = 32'h0000_0000;
    csr_except_o     = 1'b0;
    if (!rst_i) begin
      busy_o = (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (exc_req_i) begin
            exc_ack_o = 1'b1;
          end else if (mret_i) begin
            mret_ack_o = 1'b1;
          end else if (core_req_i) begin
            core_gnt_o = 1'b1;
            csr_addr_o = {20'h0_0000, core_addr_i};
            if (core_we_i) begin
              csr_we_o    = 1'b1;
              csr_wdata_o = core_wdata_i;
            end else begin
              csr_re_o = 1'b1;
            end
          end else begin
            core_gnt_o = 1'b0;
          end
        end
        S_C_RD: begin
          core_rvalid_o = 1'b1;
          core_rdata_o  = csr_rdata_i;
        end
        S_T_EPC: begin
          csr_we_o    = 1'b1;
          csr_addr_o  = ADDR_MEPC;
          csr_wdata_o = {r_pc[31:2], 2'b00};
        end
        S_T_CAUSE: begin
          csr_we_o    = 1'b1;
          csr_addr_o  = ADDR_MCAUSE;
          csr_wdata_o = r_cause;
        end
        S_T_ST_RD: begin
          csr_re_o   = 1'b1;
          csr_addr_o = ADDR_MSTATUS;
        end
        S_T_ST_WR: begin
          csr_we_o    = 1'b1;
          csr_addr_o  = ADDR_MSTATUS;
          csr_wdata_o = f_trap_mstatus(csr_rdata_i);
        end
        S_T_VEC_RD: begin
          csr_re_o     = 1'b1;
          csr_except_o = 1'b1;
          csr_addr_o   = ADDR_MTVEC;
        end
        S_T_VEC_LD: begin
          csr_re_o = 1'b0;
        end
        S_R_EPC_RD: begin
          csr_re_o   = 1'b1;
          csr_addr_o = ADDR_MEPC;
        end
        S_R_ST_RD: begin
          csr_re_o   = 1'b1;
          csr_addr_o = ADDR_MSTATUS;
        end
        S_R_ST_WR: begin
          csr_we_o    = 1'b1;
          csr_addr_o  = ADDR_MSTATUS;
          csr_wdata_o = f_mret_mstatus(csr_rdata_i);
        end
        S_REDIR: begin
          redirect_valid_o = 1'b1;
        end
        default: begin
          busy_o = 1'b1;
        end
      endcase
    end else begin
      busy_o = 1'b0;
    end
  end

endmodule
